// File: rtl/voting_pkg.sv
// Shared widths and FSM state encoding for the result reader.
package voting_pkg;
    localparam int NUM_CAND  = 4;
    localparam int COUNT_W   = 8;
    localparam int CAND_ID_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SHOW   = 3'd2,
        WINNER = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/result_reader_max_tracker.sv
// Running maximum over the snapshot scan; lowest index wins equal counts.
// The tie flag register exists only when RESULT_TIE_DETECT_EN is defined.
module max_tracker
    import voting_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [CAND_ID_W-1:0] id,
    input  logic [COUNT_W-1:0]   count,
`ifdef RESULT_TIE_DETECT_EN
    output logic                 tie_flag,
`endif
    output logic [COUNT_W-1:0]   max_cnt,
    output logic [CAND_ID_W-1:0] max_id
);
    always_ff @(posedge clock) begin
        if (!reset) begin
            max_cnt <= '0;
            max_id  <= '0;
        end else if (load || (step && count > max_cnt)) begin
            max_cnt <= count;
            max_id  <= id;
        end
    end

`ifdef RESULT_TIE_DETECT_EN
    always_ff @(posedge clock) begin
        if (!reset)
            tie_flag <= 1'b0;
        else if (load || (step && count > max_cnt))
            tie_flag <= 1'b0;
        else if (step && count == max_cnt)
            tie_flag <= 1'b1;
    end
`endif
endmodule

// File: rtl/result_reader.sv
// Snapshots four tallies, scans for the maximum, then streams per-candidate
// records and a winner record. Optional tie output: RESULT_TIE_DETECT_EN.
module result_reader
    import voting_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic [COUNT_W-1:0] cand1_vote_recvd,
    input  logic [COUNT_W-1:0] cand2_vote_recvd,
    input  logic [COUNT_W-1:0] cand3_vote_recvd,
    input  logic [COUNT_W-1:0] cand4_vote_recvd,
    input  logic               disp_ready,
    output logic               disp_valid,
    output logic [1:0]         disp_cand_id,
    output logic [7:0]         disp_count,
    output logic               disp_is_winner,
    output logic               tie,
    output logic               done
);
    state_t                 state, state_nxt;
    logic [COUNT_W-1:0]     snap [NUM_CAND];
    logic [CAND_ID_W-1:0]   idx;
    logic [COUNT_W-1:0]     max_cnt;
    logic [CAND_ID_W-1:0]   max_id;
    logic                   accept;

    assign accept = disp_valid & disp_ready;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mode) state_nxt = SCAN;
            SCAN:    if (!mode) state_nxt = IDLE;
                     else if (idx == 2'd3) state_nxt = SHOW;
            SHOW:    if (!mode) state_nxt = IDLE;
                     else if (accept && idx == 2'd3) state_nxt = WINNER;
            WINNER:  if (!mode) state_nxt = IDLE;
                     else if (accept) state_nxt = DONE;
            DONE:    if (!mode) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx walks the snapshots during SCAN, wraps to 0 and then walks records in SHOW
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx <= '0;
            for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (mode) begin
                        snap[0] <= cand1_vote_recvd;
                        snap[1] <= cand2_vote_recvd;
                        snap[2] <= cand3_vote_recvd;
                        snap[3] <= cand4_vote_recvd;
                    end
                end
                SCAN:    idx <= mode ? idx + 2'd1 : '0;
                SHOW:    if (!mode) idx <= '0;
                         else if (accept) idx <= idx + 2'd1;
                default: if (!mode) idx <= '0;
            endcase
        end
    end

`ifdef RESULT_TIE_DETECT_EN
    logic tie_flag;
`endif

    max_tracker u_max (
        .clock   (clock),
        .reset   (reset),
        .load    (state == SCAN && idx == 2'd0),
        .step    (state == SCAN && idx != 2'd0),
        .id      (idx),
        .count   (snap[idx]),
`ifdef RESULT_TIE_DETECT_EN
        .tie_flag(tie_flag),
`endif
        .max_cnt (max_cnt),
        .max_id  (max_id)
    );

`ifdef RESULT_TIE_DETECT_EN
    assign tie = (state != IDLE) & tie_flag;
`else
    assign tie = 1'b0;
`endif

    always_comb begin
        disp_valid     = 1'b0;
        disp_cand_id   = '0;
        disp_count     = '0;
        disp_is_winner = 1'b0;
        done           = (state == DONE);
        if (state == SHOW) begin
            disp_valid   = 1'b1;
            disp_cand_id = idx;
            disp_count   = snap[idx];
        end else if (state == WINNER) begin
            disp_valid     = 1'b1;
            disp_cand_id   = max_id;
            disp_count     = max_cnt;
            disp_is_winner = 1'b1;
        end
    end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 mode  input  1  0 = voting mode (block idle), 1 = result mode (scan and report).
REQ-004 cand1_vote_recvd..cand4_vote_recvd  input  8 each  current tally per candidate, from the vote counter.
REQ-005 disp_ready  input  1  downstream display accepts the current record.
REQ-006 disp_valid  output  1  a result record is presented.
REQ-007 disp_cand_id  output  2  candidate index 0..3 of the record.
REQ-008 disp_count  output  8  vote count of the record.
REQ-009 disp_is_winner  output  1  record is the winner record.
REQ-010 tie  output  1  two or more candidates share the maximum count.
REQ-011 done  output  1  all records delivered; held until mode returns to 0.

Function
REQ-012 FSM states SHALL be IDLE, SCAN, SHOW, WINNER and DONE.
REQ-013 In IDLE with mode=1, the block SHALL snapshot all four counts into internal registers and enter SCAN; later input changes SHALL be ignored until the next IDLE.
REQ-014 SCAN SHALL take exactly 4 cycles, examining one snapshot per cycle in index order 0..3 via a 2-bit scan index.
REQ-015 Index 0 SHALL load max_cnt/max_id unconditionally; later indices: count > max_cnt -> replace, clear tie flag; count == max_cnt -> set tie flag; strict compare, so the lowest index wins equal counts.
REQ-016 disp_valid SHALL first be high after the 5th rising edge, counting the edge that sampled mode=1 in IDLE.
REQ-017 SHOW SHALL present records for candidates 0,1,2,3 in order; a record advances only on a cycle with disp_valid=1 and disp_ready=1.
REQ-018 While disp_valid=1 and disp_ready=0, disp_cand_id, disp_count and disp_is_winner SHALL hold stable.
REQ-019 After candidate 3 is accepted, the block SHALL enter WINNER and present one record with disp_cand_id=max_id, disp_count=max_cnt and disp_is_winner=1.
REQ-020 On acceptance of the winner record, the block SHALL enter DONE: disp_valid=0, done=1.
REQ-021 DONE SHALL return to IDLE when mode=0; the block SHALL not rescan while mode stays 1.
REQ-022 mode=0 in any non-IDLE state SHALL abort to IDLE at the next edge, with disp_valid and done low in the following cycle.
REQ-023 All-zero counts are a legal input: every candidate shares the maximum and REQ-015 applies (winner 0, tie flag set).
REQ-024 Counts are unsigned 8-bit; no arithmetic is done beyond comparison, so no overflow handling is needed.

Reset
REQ-025 With reset=0 at an edge: state=IDLE; disp_valid, disp_is_winner, tie, done=0; disp_cand_id=0; disp_count=0; snapshots, max_cnt, max_id, scan index=0.
REQ-026 Reset SHALL take priority over mode and disp_ready, including mid-SHOW, with no partial record delivered afterwards.

Configuration
REQ-027 Macro RESULT_TIE_DETECT_EN: when defined, tie SHALL be driven from the tie flag from SCAN onward, and the winner record SHALL still carry the lowest-index maximum.
REQ-028 Without RESULT_TIE_DETECT_EN, tie SHALL be constant 0 and no tie-flag register SHALL exist.

Structure
REQ-029 Shared package voting_pkg SHALL hold NUM_CAND=4, COUNT_W=8, CAND_ID_W=2 and the FSM state enum.
REQ-030 Sub-module max_tracker SHALL hold max_cnt, max_id and the tie flag, with inputs load, step, id and count.

Verification
REQ-031 Counts 5,9,3,7, disp_ready=1 -> records (0,5),(1,9),(2,3),(3,7), then winner (1,9), tie=0, done=1.
REQ-032 Counts 4,8,8,2, RESULT_TIE_DETECT_EN defined -> winner (1,8), tie=1; macro undefined -> winner (1,8), tie=0.
REQ-033 disp_ready low for 3 cycles during record 2 -> record 2 held stable for those cycles, no record skipped or duplicated.
REQ-034 mode dropped during SHOW after record 1 -> IDLE next edge, disp_valid=0; mode raised again -> fresh scan starting at record 0.
REQ-035 All counts 0 -> winner (0,0), tie=1 when RESULT_TIE_DETECT_EN is defined.
REQ-036 reset=0 during WINNER -> all outputs at reset values after that edge; inputs changed after snapshot -> reported values equal the snapshot.
